keccak_cmd_packer: RTL

//  Host-side transmitter for the Keccak core's 64-bit command/data input stream.

---
 rtl/keccak_pkg.sv | 73 +++++++
 rtl/keccak_seg_calc.sv | 27 ++
 rtl/keccak_cmd_packer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak host packer and core datapath.
// Rates, mode encoding and command word field positions.
package keccak_pkg;

    localparam int unsigned RATE_1088 = 1088;
    localparam int unsigned RATE_576  = 576;
    localparam int unsigned RATE_1344 = 1344;

    typedef enum logic [1:0] {
        MODE_R1088  = 2'b00,
        MODE_R576   = 2'b01,
        MODE_R1344  = 2'b10,
        MODE_R1088B = 2'b11
    } mode_e;

    // Header word: {0, mode, out_len, 32'h0}
    localparam int HDR_MODE_LSB = 61;
    localparam int HDR_MODE_W   = 2;
    localparam int HDR_OLEN_LSB = 32;
    localparam int HDR_OLEN_W   = 29;

    // Segment word: {final, 31'h0, seg_len}
    localparam int SEG_FINAL_BIT = 63;
    localparam int SEG_LEN_LSB   = 0;
    localparam int SEG_LEN_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEG,
        ST_DATA
    } state_e;

    typedef struct packed {
        logic [1:0]  mode;
        logic [28:0] out_len;
    } req_t;

    function automatic logic [31:0] rate_bits(
        input logic [1:0] mode
    );
        logic [31:0] r;
        unique case (mode)
            MODE_R576:  r = RATE_576;
            MODE_R1344: r = RATE_1344;
            default:    r = RATE_1088;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] hdr_word(
        input logic [1:0]  mode,
        input logic [28:0] out_len
    );
        logic [63:0] w;
        w = '0;
        w[HDR_MODE_LSB +: HDR_MODE_W] = mode;
        w[HDR_OLEN_LSB +: HDR_OLEN_W] = out_len;
        return w;
    endfunction

    function automatic logic [63:0] seg_word(
        input logic        fin,
        input logic [31:0] len
    );
        logic [63:0] w;
        w = '0;
        w[SEG_FINAL_BIT] = fin;
        w[SEG_LEN_LSB +: SEG_LEN_W] = len;
        return w;
    endfunction

endpackage

// File: rtl/keccak_seg_calc.sv
// Segment sizing: clips remaining message bits to the per-segment
// maximum and derives the final flag, word count and tail bits.
module keccak_seg_calc
    import keccak_pkg::*;
#(
    parameter int unsigned SEG_BLOCKS = 16
) (
    input  logic [1:0]  mode,
    input  logic [31:0] rem_bits,
    output logic [31:0] seg_len,
    output logic        seg_final,
    output logic [31:0] seg_words,
    output logic [5:0]  seg_tail
);

    logic [31:0] max_bits;

    always_comb begin
        max_bits  = SEG_BLOCKS * rate_bits(mode);
        seg_final = (rem_bits <= max_bits);
        seg_len   = seg_final ? rem_bits : max_bits;
        seg_words = {6'b0, seg_len[31:6]}
                  + {31'b0, |seg_len[5:0]};
        seg_tail  = seg_len[5:0];
    end

endmodule

// File: rtl/keccak_cmd_packer.sv
// Host-side packer: header word, then length-prefixed segments
// of message words streamed into the Keccak core din port.
module keccak_cmd_packer
    import keccak_pkg::*;
#(
    parameter int unsigned SEG_BLOCKS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [28:0] out_len,
    input  logic [31:0] msg_len,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [63:0] msg_data,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic [63:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] words_q, words_d;
    logic [5:0]  tail_q, tail_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [31:0] seg_len;
    logic        seg_final;
    logic [31:0] seg_words;
    logic [5:0]  seg_tail;
    logic [63:0] tail_mask;
    logic        last_word;

    keccak_seg_calc #(
        .SEG_BLOCKS (SEG_BLOCKS)
    ) u_calc (
        .mode      (req_q.mode),
        .rem_bits  (rem_q),
        .seg_len   (seg_len),
        .seg_final (seg_final),
        .seg_words (seg_words),
        .seg_tail  (seg_tail)
    );

    // tail of 0 means the last word is full
    always_comb begin
        tail_mask = '1;
        if (tail_q != 6'd0)
            tail_mask = ~({64{1'b1}} >> tail_q);
    end

    assign last_word = (words_q == 32'd1);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        rem_d     = rem_q;
        words_d   = words_q;
        tail_d    = tail_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        msg_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (msg_len[2:0] == 3'd0) begin
                        req_d.mode    = mode;
                        req_d.out_len = out_len;
                        rem_d         = msg_len;
                        state_d       = ST_HDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_word(req_q.mode,
                                    req_q.out_len);
                if (tx_ready)
                    state_d = ST_SEG;
            end
            ST_SEG: begin
                tx_valid = 1'b1;
                tx_data  = seg_word(seg_final, seg_len);
                if (tx_ready) begin
                    words_d = seg_words;
                    tail_d  = seg_tail;
                    rem_d   = rem_q - seg_len;
                    if (seg_words == 32'd0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                tx_valid  = msg_valid;
                msg_ready = tx_ready;
                tx_data   = last_word ? (msg_data & tail_mask)
                                      : msg_data;
                if (msg_valid && tx_ready) begin
                    words_d = words_q - 32'd1;
                    if (last_word) begin
                        if (rem_q != 32'd0) begin
                            state_d = ST_SEG;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            rem_q   <= '0;
            words_q <= '0;
            tail_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rem_q   <= rem_d;
            words_q <= words_d;
            tail_q  <= tail_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule
